// File: rtl/clock_pkg.sv
`default_nettype none
// ============================================================================
// Module   : clock_pkg
// Purpose  : Shared types and digit-packing helper for the time_keeper slice.
// Revision : 1.0
// ============================================================================
package clock_pkg;

    typedef enum logic [2:0] {
        RUN         = 3'd0,
        SET_HR      = 3'd1,
        SET_MIN     = 3'd2,
        SET_ALM_HR  = 3'd3,
        SET_ALM_MIN = 3'd4
    } state_t;

    typedef struct packed {
        logic       en;
        logic [3:0] bcd;
        logic       dp;
    } digit_t;

    localparam digit_t BLANK_DIGIT = '{en: 1'b0, bcd: 4'h0, dp: 1'b1};

    function automatic digit_t pack_digit(input logic [3:0] bcd, input logic en, input logic dp);
        digit_t d;
        d.en  = en;
        d.bcd = bcd;
        d.dp  = dp;
        return d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_mod_counter.sv
`default_nettype none
// ============================================================================
// Module   : bcd_mod_counter
// Purpose  : Two-digit BCD counter wrapping after MAX_TENS:MAX_ONES_AT_MAX_TENS.
// Revision : 1.0
// ============================================================================
module bcd_mod_counter #(
    parameter int         MAX_TENS             = 5,
    parameter int         MAX_ONES_AT_MAX_TENS = 9,
    parameter logic [7:0] RST_VAL              = 8'h00
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       inc,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic       carry_out
);

    logic at_max;

    assign at_max    = (tens == 4'(MAX_TENS)) && (ones == 4'(MAX_ONES_AT_MAX_TENS));
    assign carry_out = inc && at_max;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tens <= RST_VAL[7:4];
            ones <= RST_VAL[3:0];
        end else if (clear) begin
            tens <= 4'd0;
            ones <= 4'd0;
        end else if (inc) begin
            if (at_max) begin
                tens <= 4'd0;
                ones <= 4'd0;
            end else if (ones == 4'd9) begin
                ones <= 4'd0;
                tens <= tens + 4'd1;
            end else begin
                ones <= ones + 4'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/time_keeper.sv
`default_nettype none
// ============================================================================
// Module   : time_keeper
// Purpose  : 24 h BCD clock with alarm, button-driven set FSM and 8-digit output.
// Revision : 1.0
// ============================================================================
module time_keeper
    import clock_pkg::*;
#(
    parameter int         TICK_DIV    = 100_000_000,
    parameter logic [7:0] ALM_HR_RST  = 8'h06,
    parameter logic [7:0] ALM_MIN_RST = 8'h00
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       mode_btn,
    input  logic       inc_btn,
    input  logic       alarm_en,
    output logic [5:0] l0,
    output logic [5:0] l1,
    output logic [5:0] l2,
    output logic [5:0] l3,
    output logic [5:0] l4,
    output logic [5:0] l5,
    output logic [5:0] l6,
    output logic [5:0] l7,
    output logic       alarm_match
);

    localparam int               CNT_W    = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(TICK_DIV / 2);

    state_t           state;
    logic [CNT_W-1:0] presc;
    logic             sec_tick;
    logic             blink_on;
    logic             inc_eff;
    logic             leave_set_min;
    logic             time_runs;

    logic [3:0] sec_t, sec_o, min_t, min_o, hr_t, hr_o;
    logic [3:0] alm_hr_t, alm_hr_o, alm_min_t, alm_min_o;
    logic       sec_carry, min_carry;
    logic       hr_carry_unused, alm_hr_carry_unused, alm_min_carry_unused;

    digit_t disp_next [8];
    digit_t disp_q    [8];

    assign sec_tick      = (presc == CNT_MAX);
    assign blink_on      = (presc < CNT_HALF);
    assign inc_eff       = inc_btn && !mode_btn;
    assign leave_set_min = mode_btn && (state == SET_MIN);
    assign time_runs     = (state == RUN) || (state == SET_ALM_HR) || (state == SET_ALM_MIN);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc <= '0;
        end else if (leave_set_min || sec_tick) begin
            presc <= '0;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= RUN;
        end else if (mode_btn) begin
            case (state)
                RUN:        state <= SET_HR;
                SET_HR:     state <= SET_MIN;
                SET_MIN:    state <= SET_ALM_HR;
                SET_ALM_HR: state <= SET_ALM_MIN;
                default:    state <= RUN;
            endcase
        end
    end

    bcd_mod_counter #(.MAX_TENS(5), .MAX_ONES_AT_MAX_TENS(9), .RST_VAL(8'h00)) u_sec (
        .clk       (clk),
        .reset     (reset),
        .clear     (leave_set_min),
        .inc       (sec_tick && time_runs),
        .tens      (sec_t),
        .ones      (sec_o),
        .carry_out (sec_carry)
    );

    bcd_mod_counter #(.MAX_TENS(5), .MAX_ONES_AT_MAX_TENS(9), .RST_VAL(8'h00)) u_min (
        .clk       (clk),
        .reset     (reset),
        .clear     (1'b0),
        .inc       (sec_carry || (inc_eff && (state == SET_MIN))),
        .tens      (min_t),
        .ones      (min_o),
        .carry_out (min_carry)
    );

    // A button-driven minute wrap must not bump the hours, hence the time_runs gate.
    bcd_mod_counter #(.MAX_TENS(2), .MAX_ONES_AT_MAX_TENS(3), .RST_VAL(8'h00)) u_hr (
        .clk       (clk),
        .reset     (reset),
        .clear     (1'b0),
        .inc       ((min_carry && time_runs) || (inc_eff && (state == SET_HR))),
        .tens      (hr_t),
        .ones      (hr_o),
        .carry_out (hr_carry_unused)
    );

    bcd_mod_counter #(.MAX_TENS(2), .MAX_ONES_AT_MAX_TENS(3), .RST_VAL(ALM_HR_RST)) u_alm_hr (
        .clk       (clk),
        .reset     (reset),
        .clear     (1'b0),
        .inc       (inc_eff && (state == SET_ALM_HR)),
        .tens      (alm_hr_t),
        .ones      (alm_hr_o),
        .carry_out (alm_hr_carry_unused)
    );

    bcd_mod_counter #(.MAX_TENS(5), .MAX_ONES_AT_MAX_TENS(9), .RST_VAL(ALM_MIN_RST)) u_alm_min (
        .clk       (clk),
        .reset     (reset),
        .clear     (1'b0),
        .inc       (inc_eff && (state == SET_ALM_MIN)),
        .tens      (alm_min_t),
        .ones      (alm_min_o),
        .carry_out (alm_min_carry_unused)
    );

    always_comb begin
        logic alarm_view;
        logic hide_hi;
        logic hide_mid;
        alarm_view = (state == SET_ALM_HR) || (state == SET_ALM_MIN);
        hide_hi    = ((state == SET_HR)  || (state == SET_ALM_HR))  && !blink_on;
        hide_mid   = ((state == SET_MIN) || (state == SET_ALM_MIN)) && !blink_on;
        for (int i = 0; i < 8; i++) begin
            disp_next[i] = BLANK_DIGIT;
        end
        disp_next[7] = pack_digit(alarm_view ? alm_hr_t  : hr_t,  !hide_hi,  1'b1);
        disp_next[6] = pack_digit(alarm_view ? alm_hr_o  : hr_o,  !hide_hi,  !alarm_view);
        disp_next[4] = pack_digit(alarm_view ? alm_min_t : min_t, !hide_mid, 1'b1);
        disp_next[3] = pack_digit(alarm_view ? alm_min_o : min_o, !hide_mid, 1'b1);
        if (!alarm_view) begin
            disp_next[1] = pack_digit(sec_t, 1'b1, 1'b1);
            disp_next[0] = pack_digit(sec_o, 1'b1, !(alarm_en && (state == RUN)));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) begin
                disp_q[i] <= ((i == 2) || (i == 5)) ? BLANK_DIGIT : pack_digit(4'h0, 1'b1, 1'b1);
            end
            alarm_match <= 1'b0;
        end else begin
            for (int i = 0; i < 8; i++) begin
                disp_q[i] <= disp_next[i];
            end
            alarm_match <= alarm_en && ({hr_t, hr_o} == {alm_hr_t, alm_hr_o})
                                    && ({min_t, min_o} == {alm_min_t, alm_min_o});
        end
    end

    assign l0 = disp_q[0];
    assign l1 = disp_q[1];
    assign l2 = disp_q[2];
    assign l3 = disp_q[3];
    assign l4 = disp_q[4];
    assign l5 = disp_q[5];
    assign l6 = disp_q[6];
    assign l7 = disp_q[7];

endmodule
`default_nettype wire

// File: tb/tb_time_keeper.sv
`default_nettype none
// ============================================================================
// Module   : tb_time_keeper
// Purpose  : Scoreboard bench for time_keeper driven by a behavioural clock model.
// Revision : 1.0
// ============================================================================
module tb_time_keeper;

    localparam int TD = 4;
    localparam logic [47:0] RST_DISP = {6'b100001, 6'b100001, 6'b000001, 6'b100001,
                                        6'b100001, 6'b000001, 6'b100001, 6'b100001};

    logic clk = 1'b0;
    logic reset;
    logic mode_btn;
    logic inc_btn;
    logic alarm_en;
    logic [5:0] l0, l1, l2, l3, l4, l5, l6, l7;
    logic alarm_match;
    logic [47:0] disp;

    assign disp = {l7, l6, l5, l4, l3, l2, l1, l0};

    time_keeper #(
        .TICK_DIV    (TD),
        .ALM_HR_RST  (8'h06),
        .ALM_MIN_RST (8'h00)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .mode_btn    (mode_btn),
        .inc_btn     (inc_btn),
        .alarm_en    (alarm_en),
        .l0          (l0),
        .l1          (l1),
        .l2          (l2),
        .l3          (l3),
        .l4          (l4),
        .l5          (l5),
        .l6          (l6),
        .l7          (l7),
        .alarm_match (alarm_match)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [47:0] disp;
        logic        match;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   match_hi = 0;
    int   m_state, m_h, m_m, m_s, m_ah, m_am, m_cnt;
    logic [23:0] bcd_now;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [5:0] dg(input logic en, input int v, input logic dp);
        logic [3:0] b;
        b = 4'(v);
        return {en, b, dp};
    endfunction

    function automatic logic [23:0] bcd_of(input logic [47:0] d);
        return {d[46:43], d[40:37], d[28:25], d[22:19], d[10:7], d[4:1]};
    endfunction

    function automatic logic [47:0] exp_disp();
        logic [5:0] d [8];
        logic bl;
        bl = (m_cnt < TD / 2);
        for (int i = 0; i < 8; i++) d[i] = 6'b000001;
        if (m_state < 3) begin
            d[7] = dg(m_state != 1 || bl, m_h / 10, 1'b1);
            d[6] = dg(m_state != 1 || bl, m_h % 10, 1'b1);
            d[4] = dg(m_state != 2 || bl, m_m / 10, 1'b1);
            d[3] = dg(m_state != 2 || bl, m_m % 10, 1'b1);
            d[1] = dg(1'b1, m_s / 10, 1'b1);
            d[0] = dg(1'b1, m_s % 10, !(alarm_en && m_state == 0));
        end else begin
            d[7] = dg(m_state != 3 || bl, m_ah / 10, 1'b1);
            d[6] = dg(m_state != 3 || bl, m_ah % 10, 1'b0);
            d[4] = dg(m_state != 4 || bl, m_am / 10, 1'b1);
            d[3] = dg(m_state != 4 || bl, m_am % 10, 1'b1);
        end
        return {d[7], d[6], d[5], d[4], d[3], d[2], d[1], d[0]};
    endfunction

    task automatic model_step(input logic md, input logic inc);
        logic tick;
        logic ie;
        tick = (m_cnt == TD - 1);
        ie   = inc && !md;
        if (tick && (m_state == 0 || m_state >= 3)) begin
            m_s++;
            if (m_s == 60) begin
                m_s = 0;
                m_m++;
                if (m_m == 60) begin
                    m_m = 0;
                    m_h = (m_h + 1) % 24;
                end
            end
        end
        if (ie) begin
            case (m_state)
                1: m_h  = (m_h + 1) % 24;
                2: m_m  = (m_m + 1) % 60;
                3: m_ah = (m_ah + 1) % 24;
                4: m_am = (m_am + 1) % 60;
                default: ;
            endcase
        end
        m_cnt = (m_cnt + 1) % TD;
        if (md) begin
            if (m_state == 2) begin
                m_s   = 0;
                m_cnt = 0;
            end
            m_state = (m_state + 1) % 5;
        end
    endtask

    task automatic cycle(input logic md, input logic inc);
        exp_t e;
        mode_btn = md;
        inc_btn  = inc;
        e.disp   = exp_disp();
        e.match  = alarm_en && (m_h == m_ah) && (m_m == m_am);
        exp_q.push_back(e);
        model_step(md, inc);
        @(posedge clk);
        #1;
        mode_btn = 1'b0;
        inc_btn  = 1'b0;
        e = exp_q.pop_front();
        check("disp", 64'(disp), 64'(e.disp));
        check("match", 64'(alarm_match), 64'(e.match));
        if (alarm_match) match_hi++;
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(1'b0, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("rst_disp", 64'(disp), 64'(RST_DISP));
        check("rst_match", 64'(alarm_match), 64'(0));
        @(posedge clk);
        #1;
        check("rst_hold", 64'(disp), 64'(RST_DISP));
        reset   = 1'b0;
        m_state = 0;
        m_h     = 0;
        m_m     = 0;
        m_s     = 0;
        m_ah    = 6;
        m_am    = 0;
        m_cnt   = 0;
        exp_q.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b1;
        mode_btn = 1'b0;
        inc_btn  = 1'b0;
        alarm_en = 1'b0;
        do_reset();

        // One minute of running from reset.
        idle(241);
        check("t1_bcd", 64'(bcd_of(disp)), 64'(24'h000100));
        check("t1_match", 64'(alarm_match), 64'(0));

        // Preload 23:59 then let seconds run to 58 in the alarm-set states.
        do_reset();
        cycle(1'b1, 1'b0);
        repeat (23) cycle(1'b0, 1'b1);
        cycle(1'b1, 1'b0);
        repeat (59) cycle(1'b0, 1'b1);
        cycle(1'b1, 1'b0);
        idle(232);
        cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b0);
        idle(7);
        check("t2_midnight", 64'(bcd_of(disp)), 64'(24'h000000));
        idle(4);
        check("t2_rollover", 64'(bcd_of(disp)), 64'(24'h000001));

        // Hours wrap in SET_HR, seconds frozen.
        cycle(1'b1, 1'b0);
        repeat (25) cycle(1'b0, 1'b1);
        idle(1);
        check("t3_hr_wrap", 64'(bcd_of(disp)), 64'(24'h010001));

        // mode and inc together in SET_MIN.
        cycle(1'b1, 1'b0);
        idle(3);
        cycle(1'b1, 1'b1);
        idle(1);
        bcd_now = bcd_of(disp);
        check("t5_alm_view", 64'(bcd_now), 64'(24'h060000));
        check("t5_alm_dp", 64'(disp[36]), 64'(0));
        cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b0);
        idle(1);
        check("t5_min_kept", 64'(bcd_of(disp)), 64'(24'h010000));

        // Alarm at 00:02.
        do_reset();
        repeat (3) cycle(1'b1, 1'b0);
        repeat (18) cycle(1'b0, 1'b1);
        cycle(1'b1, 1'b0);
        repeat (2) cycle(1'b0, 1'b1);
        cycle(1'b1, 1'b0);
        alarm_en = 1'b1;
        match_hi = 0;
        idle(960);
        check("t4_match_len", 64'(match_hi), 64'(240));
        alarm_en = 1'b0;
        cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b0);
        repeat ((62 - m_m) % 60) cycle(1'b0, 1'b1);
        repeat (3) cycle(1'b1, 1'b0);
        match_hi = 0;
        idle(200);
        check("t4_disabled", 64'(match_hi), 64'(0));
        alarm_en = 1'b1;
        idle(2);
        check("t4_enable", 64'(alarm_match), 64'(1));

        // Reset in the middle of an alarm-minute edit.
        alarm_en = 1'b0;
        repeat (4) cycle(1'b1, 1'b0);
        repeat (3) cycle(1'b0, 1'b1);
        idle(2);
        do_reset();
        idle(2);
        check("t6_time", 64'(bcd_of(disp)), 64'(24'h000000));
        repeat (3) cycle(1'b1, 1'b0);
        idle(1);
        check("t6_alarm", 64'(bcd_of(disp)), 64'(24'h060000));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
